// File: rtl/arbiter4x1_pkg.sv
// Shared types and defaults for the four-way round-robin arbiter.
package arbiter4x1_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StOwn  = 1'b1
  } arb_state_e;

  localparam int unsigned DefWide    = 32;
  localparam int unsigned DefMaxHold = 8;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

endpackage

// File: rtl/arbiter4x1_mux4x1.sv
// Four-input payload mux steered by the arbiter's registered select.
module arbiter4x1_mux4x1 #(
  parameter int unsigned WIDE = 32
) (
  input  logic [WIDE-1:0] in_00,
  input  logic [WIDE-1:0] in_01,
  input  logic [WIDE-1:0] in_10,
  input  logic [WIDE-1:0] in_11,
  input  logic [1:0]      slct,
  output logic [WIDE-1:0] out
);

  always_comb begin
    out = in_00;
    unique case (slct)
      2'd0: out = in_00;
      2'd1: out = in_01;
      2'd2: out = in_10;
      2'd3: out = in_11;
      default: out = in_00;
    endcase
  end

endmodule

// File: rtl/arbiter4x1.sv
// Round-robin arbiter with persistent ownership and bounded hold time under contention.
module arbiter4x1
  import arbiter4x1_pkg::*;
#(
  parameter int unsigned WIDE     = DefWide,
  parameter int unsigned MAX_HOLD = DefMaxHold
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      req,
  input  logic [WIDE-1:0] in_00,
  input  logic [WIDE-1:0] in_01,
  input  logic [WIDE-1:0] in_10,
  input  logic [WIDE-1:0] in_11,
  output logic [3:0]      gnt,
  output logic [1:0]      slct,
  output logic [WIDE-1:0] out,
  output logic            out_valid,
  output logic            busy
);

  localparam logic [3:0] HoldLast = 4'(MAX_HOLD - 1);

  arb_state_e state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] slct_q, slct_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] hold_q, hold_d;

  logic [3:0] others;
  logic [1:0] next_ptr;
  logic       release_own;
  pick_t      pick_idle, pick_rel;

  // First set bit of r in order p, p+1, p+2, p+3 (mod 4).
  function automatic pick_t rr_pick(input logic [3:0] r, input logic [1:0] p);
    pick_t      res;
    logic [1:0] c;
    res = '0;
    for (int k = 3; k >= 0; k--) begin
      c = p + 2'(k);
      if (r[c]) begin
        res.found = 1'b1;
        res.idx   = c;
      end
    end
    return res;
  endfunction

  always_comb begin
    others      = req & ~gnt_q;
    next_ptr    = slct_q + 2'd1;
    pick_idle   = rr_pick(req, ptr_q);
    pick_rel    = rr_pick(others, next_ptr);
    // A dropped request and an expired hold both hand off the same way.
    release_own = !req[slct_q] || ((hold_q == HoldLast) && (|others));

    state_d = state_q;
    gnt_d   = gnt_q;
    slct_d  = slct_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;

    case (state_q)
      StIdle: begin
        gnt_d = 4'b0000;
        if (pick_idle.found) begin
          state_d = StOwn;
          gnt_d   = 4'b0001 << pick_idle.idx;
          slct_d  = pick_idle.idx;
          hold_d  = 4'd0;
        end
      end
      StOwn: begin
        if (release_own) begin
          ptr_d  = next_ptr;
          hold_d = 4'd0;
          if (pick_rel.found) begin
            gnt_d  = 4'b0001 << pick_rel.idx;
            slct_d = pick_rel.idx;
          end else begin
            state_d = StIdle;
            gnt_d   = 4'b0000;
          end
        end else if (hold_q != HoldLast) begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      gnt_q   <= 4'b0000;
      slct_q  <= 2'd0;
      ptr_q   <= 2'd0;
      hold_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      slct_q  <= slct_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt       = gnt_q;
  assign slct      = slct_q;
  assign busy      = (state_q == StOwn);
  assign out_valid = (|gnt_q) && req[slct_q];

  arbiter4x1_mux4x1 #(
    .WIDE(WIDE)
  ) u_mux (
    .in_00(in_00),
    .in_01(in_01),
    .in_10(in_10),
    .in_11(in_11),
    .slct (slct_q),
    .out  (out)
  );

endmodule

// File: tb/tb_arbiter4x1.sv
// Directed scoreboard bench: stimulus queues expected outputs, a negedge monitor checks them.
module tb_arbiter4x1;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] in_00, in_01, in_10, in_11;
  logic [3:0]  gnt;
  logic [1:0]  slct;
  logic [31:0] out;
  logic        out_valid;
  logic        busy;

  arbiter4x1 #(
    .WIDE    (32),
    .MAX_HOLD(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .in_00    (in_00),
    .in_01    (in_01),
    .in_10    (in_10),
    .in_11    (in_11),
    .gnt      (gnt),
    .slct     (slct),
    .out      (out),
    .out_valid(out_valid),
    .busy     (busy)
  );

  typedef struct {
    int         cyc;
    logic [3:0] gnt;
    logic [1:0] slct;
    logic       ov;
    logic       busy;
    string      name;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          passed = 0;
  int          total = 0;
  logic [31:0] pay[4];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] want);
    total++;
    if (act === want) passed++;
    else $display("FAIL %s %s: got %h want %h", nm, fld, act, want);
  endtask

  // Monitor: compares each queued expectation in the cycle it targets.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        check(e.name, "stale", 32'(e.cyc), 32'(cyc));
      end else begin
        check(e.name, "gnt", 32'(gnt), 32'(e.gnt));
        check(e.name, "slct", 32'(slct), 32'(e.slct));
        check(e.name, "busy", 32'(busy), 32'(e.busy));
        check(e.name, "out_valid", 32'(out_valid), 32'(e.ov));
        check(e.name, "out", out, pay[e.slct]);
      end
    end
  end

  task automatic step(input logic r_rst, input logic [3:0] r_req, input logic [3:0] e_gnt,
                      input logic [1:0] e_slct, input logic e_busy, input string nm);
    exp_t e;
    @(negedge clk);
    #1;
    rst    = r_rst;
    req    = r_req;
    e.cyc  = cyc + 1;
    e.gnt  = e_gnt;
    e.slct = e_slct;
    e.busy = e_busy;
    e.ov   = e_busy;
    e.name = nm;
    sb.push_back(e);
  endtask

  initial begin
    logic [1:0] own;
    rst    = 1'b1;
    req    = 4'b0000;
    in_00  = 32'hA000_0000;
    in_01  = 32'hA000_0001;
    in_10  = 32'd6;
    in_11  = 32'hA000_0003;
    pay[0] = in_00;
    pay[1] = in_01;
    pay[2] = in_10;
    pay[3] = in_11;

    step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, "reset");
    step(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, "single_req2");
    step(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, "release_to_idle");
    step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, "reset2");

    // Full contention: each owner keeps the grant for exactly 8 cycles.
    for (int i = 0; i < 40; i++) begin
      own = 2'((i / 8) % 4);
      step(1'b0, 4'b1111, 4'b0001 << own, own, 1'b1, "rotate_all");
    end

    step(1'b0, 4'b0011, 4'b0010, 2'd1, 1'b1, "forced_to_1");
    step(1'b0, 4'b0011, 4'b0010, 2'd1, 1'b1, "hold_1");
    step(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, "drop1_wrap_to_0");
    step(1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, "drop0_to_3");
    for (int i = 0; i < 40; i++) step(1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, "sole_3");
    // Saturated hold counter means a newcomer forces rotation immediately.
    step(1'b0, 4'b1001, 4'b0001, 2'd0, 1'b1, "sat_forced_to_0");

    step(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, "drop0_to_2");
    for (int i = 0; i < 7; i++) step(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, "hold_2");
    step(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, "drop_at_limit");

    step(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, "to_2_again");
    step(1'b1, 4'b0100, 4'b0000, 2'd0, 1'b0, "reset_mid");
    step(1'b0, 4'b1100, 4'b0100, 2'd2, 1'b1, "post_reset_prio");
    step(1'b0, 4'b1100, 4'b0100, 2'd2, 1'b1, "post_reset_hold");

    repeat (3) @(negedge clk);
    #2;
    if (sb.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
